// File: rtl/stepper_exec_pkg.sv
// Move-queue entry layout shared between the queue writer and the step executor.
// One 64-bit entry = initial interval, signed per-step increment, step count.
package stepper_exec_pkg;

  localparam int MQ_INTERVAL_LSB = 32;
  localparam int MQ_ADD_LSB      = 16;
  localparam int MQ_COUNT_LSB    = 0;

  localparam int MQ_INTERVAL_W   = 32;
  localparam int MQ_ADD_W        = 16;
  localparam int MQ_COUNT_W      = 16;

  typedef struct packed {
    logic [MQ_INTERVAL_W-1:0]  interval;
    logic signed [MQ_ADD_W-1:0] add;
    logic [MQ_COUNT_W-1:0]     count;
  } mq_entry_t;

  function automatic mq_entry_t mq_unpack(input logic [63:0] d);
    mq_entry_t e;
    e.interval = d[MQ_INTERVAL_LSB +: MQ_INTERVAL_W];
    e.add      = d[MQ_ADD_LSB +: MQ_ADD_W];
    e.count    = d[MQ_COUNT_LSB +: MQ_COUNT_W];
    return e;
  endfunction

endpackage

// File: rtl/stepper_exec_pulse.sv
// Fixed-width step pulse generator: a fire strobe starts a PULSE_TICKS-cycle
// high pulse on step_pin beginning the following cycle.
module step_pulse_gen #(
  parameter int PULSE_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic fire,
  output logic step_pin
);

  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_TICKS);

  logic [7:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= 8'd0;
    end else if (fire) begin
      cnt_reg <= PULSE_LOAD;
    end else if (cnt_reg != 8'd0) begin
      cnt_reg <= cnt_reg - 8'd1;
    end
  end

  assign step_pin = (cnt_reg != 8'd0);

endmodule

// File: rtl/stepper_exec.sv
// Move-queue consumer: pops timed move entries and turns them into step pulses,
// chaining consecutive moves with no idle cycle between them.
module stepper_exec
  import stepper_exec_pkg::*;
#(
  parameter int PULSE_TICKS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [63:0] mq_data,
  input  logic        mq_avail,
  output logic        mq_pull,
  output logic        step_pin,
  output logic        busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Intervals shorter than the pulse itself would overlap pulses.
  localparam logic [31:0] MIN_TICKS = 32'(PULSE_TICKS + 1);

  function automatic logic [31:0] eff(input logic [31:0] x);
    return (x < MIN_TICKS) ? MIN_TICKS : x;
  endfunction

  logic [0:0]  state_reg;
  logic [31:0] timer_reg;
  logic [31:0] interval_reg;
  logic [15:0] add_reg;
  logic [15:0] count_reg;

  mq_entry_t   entry;
  logic        run;
  logic        event_due;
  logic        finish;
  logic        load_due;
  logic        fire;
  logic [31:0] interval_next;

  assign entry         = mq_unpack(mq_data);
  assign run           = (state_reg == ST_RUN);
  assign event_due     = run && (timer_reg == 32'd1);
  // Finishing event: last step (count 1) or a pure delay (count 0).
  assign finish        = event_due && (count_reg <= 16'd1);
  assign load_due      = !run || finish;
  assign mq_pull       = !rst && enable && mq_avail && load_due;
  assign fire          = !rst && enable && event_due && (count_reg != 16'd0);
  assign interval_next = interval_reg + {{16{add_reg[15]}}, add_reg};
  assign busy          = run;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      timer_reg    <= 32'd0;
      interval_reg <= 32'd0;
      add_reg      <= 16'd0;
      count_reg    <= 16'd0;
    end else if (!enable) begin
      state_reg <= ST_IDLE;
    end else if (mq_pull) begin
      interval_reg <= entry.interval;
      add_reg      <= entry.add;
      count_reg    <= entry.count;
      timer_reg    <= eff(entry.interval);
      state_reg    <= ST_RUN;
    end else if (run) begin
      if (event_due) begin
        if (count_reg != 16'd0) begin
          count_reg    <= count_reg - 16'd1;
          interval_reg <= interval_next;
          timer_reg    <= eff(interval_next);
        end
        if (finish) begin
          state_reg <= ST_IDLE;
        end
      end else begin
        timer_reg <= timer_reg - 32'd1;
      end
    end
  end

  step_pulse_gen #(
    .PULSE_TICKS(PULSE_TICKS)
  ) u_pulse (
    .clk     (clk),
    .rst     (rst),
    .fire    (fire),
    .step_pin(step_pin)
  );

endmodule

// File: tb/tb_stepper_exec.sv
// Scoreboard bench for stepper_exec: stimulus queues expected pull/step cycles
// and level probes; a negedge monitor pops and compares as the DUT responds.
module tb_stepper_exec;

  localparam int PT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [63:0] mq_data = 64'd0;
  logic        mq_avail = 1'b0;
  logic        mq_pull;
  logic        step_pin;
  logic        busy;

  always #5 clk = ~clk;

  stepper_exec #(.PULSE_TICKS(PT)) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .mq_data (mq_data),
    .mq_avail(mq_avail),
    .mq_pull (mq_pull),
    .step_pin(step_pin),
    .busy    (busy)
  );

  typedef struct {
    int   cyc;
    int   sig;
    logic val;
  } probe_t;

  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          pull_exp[$];
  int          step_exp[$];
  probe_t      probe_q[$];
  logic [63:0] q[$];
  logic [63:0] pend_q[$];
  logic        pull_seen = 1'b0;
  logic        step_prev = 1'b0;
  int          hi_cnt = 0;
  bit          width_chk = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mk(input logic [31:0] iv, input logic [15:0] ad,
                                     input logic [15:0] ct);
    return {iv, ad, ct};
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d want %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic probe(input int c, input int s, input logic v);
    probe_t p;
    p.cyc = c;
    p.sig = s;
    p.val = v;
    probe_q.push_back(p);
  endtask

  task automatic go(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Queue model: pops the head one edge after a pull is observed.
  always @(posedge clk) begin
    #1;
    if (pull_seen && q.size() > 0) void'(q.pop_front());
    while (pend_q.size() > 0) q.push_back(pend_q.pop_front());
    mq_avail = (q.size() > 0);
    mq_data  = (q.size() > 0) ? q[0] : 64'd0;
  end

  // Monitor
  always @(negedge clk) begin
    logic v;
    probe_t p;
    if (mq_pull === 1'b1) begin
      if (pull_exp.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pull_unexpected at cycle %0d: got 1 want 0", cyc);
      end else begin
        chk("pull_cycle", cyc, pull_exp.pop_front());
      end
    end
    pull_seen = (mq_pull === 1'b1);

    if (step_pin === 1'b1 && !step_prev) begin
      if (step_exp.size() == 0) begin
        total++;
        bad++;
        $display("FAIL step_unexpected at cycle %0d: got edge want none", cyc);
      end else begin
        chk("step_edge_cycle", cyc, step_exp.pop_front());
      end
    end
    if (step_pin === 1'b1) begin
      hi_cnt++;
    end else if (step_prev) begin
      if (width_chk) chk("pulse_width", hi_cnt, PT);
      hi_cnt = 0;
    end
    step_prev = (step_pin === 1'b1);

    while (probe_q.size() > 0 && probe_q[0].cyc <= cyc) begin
      p = probe_q.pop_front();
      v = (p.sig == 0) ? busy : (p.sig == 1) ? step_pin : mq_pull;
      chk((p.sig == 0) ? "busy" : (p.sig == 1) ? "step_pin" : "mq_pull", v, p.val);
    end
  end

  initial begin
    int t;
    @(posedge clk);
    #2;
    probe(2, 0, 1'b0);
    probe(2, 1, 1'b0);
    probe(2, 2, 1'b0);
    go(4);
    rst = 1'b0;
    go(6);
    enable = 1'b1;

    // single move, constant interval
    go(10);
    t = cyc + 1;
    pend_q.push_back(mk(32'd100, 16'd0, 16'd3));
    pull_exp.push_back(t);
    step_exp.push_back(t + 101);
    step_exp.push_back(t + 201);
    step_exp.push_back(t + 301);
    probe(t, 0, 1'b0);
    probe(t + 1, 0, 1'b1);
    probe(t + 300, 0, 1'b1);
    probe(t + 301, 0, 1'b0);
    $display("txn single: pull@%0d steps@%0d,%0d,%0d", t, t + 101, t + 201, t + 301);
    go(t + 320);

    // acceleration with negative increment
    t = cyc + 1;
    pend_q.push_back(mk(32'd1000, 16'hFF9C, 16'd4));
    pull_exp.push_back(t);
    step_exp.push_back(t + 1001);
    step_exp.push_back(t + 1901);
    step_exp.push_back(t + 2701);
    step_exp.push_back(t + 3401);
    probe(t + 3400, 0, 1'b1);
    probe(t + 3401, 0, 1'b0);
    $display("txn accel: pull@%0d first step@%0d", t, t + 1001);
    go(t + 3420);

    // back-to-back chain
    t = cyc + 1;
    pend_q.push_back(mk(32'd50, 16'd0, 16'd1));
    pend_q.push_back(mk(32'd60, 16'd0, 16'd1));
    pull_exp.push_back(t);
    pull_exp.push_back(t + 50);
    step_exp.push_back(t + 51);
    step_exp.push_back(t + 111);
    probe(t + 50, 0, 1'b1);
    probe(t + 51, 0, 1'b1);
    probe(t + 110, 0, 1'b1);
    probe(t + 111, 0, 1'b0);
    $display("txn chain: pulls@%0d,%0d steps@%0d,%0d", t, t + 50, t + 51, t + 111);
    go(t + 130);

    // interval clamped to PULSE_TICKS+1
    t = cyc + 1;
    pend_q.push_back(mk(32'd2, 16'd0, 16'd2));
    pull_exp.push_back(t);
    step_exp.push_back(t + 6);
    step_exp.push_back(t + 11);
    probe(t + 11, 0, 1'b0);
    $display("txn clamp: pull@%0d steps@%0d,%0d", t, t + 6, t + 11);
    go(t + 30);

    // pure delay followed by a one-step move
    t = cyc + 1;
    pend_q.push_back(mk(32'd30, 16'd0, 16'd0));
    pend_q.push_back(mk(32'd40, 16'd0, 16'd1));
    pull_exp.push_back(t);
    pull_exp.push_back(t + 30);
    step_exp.push_back(t + 71);
    probe(t + 30, 0, 1'b1);
    probe(t + 31, 1, 1'b0);
    probe(t + 71, 0, 1'b0);
    $display("txn delay: pulls@%0d,%0d step@%0d", t, t + 30, t + 71);
    go(t + 90);

    // queue runs dry, then an entry arrives later
    t = cyc + 1;
    pend_q.push_back(mk(32'd20, 16'd0, 16'd1));
    pull_exp.push_back(t);
    step_exp.push_back(t + 21);
    probe(t + 21, 0, 1'b0);
    probe(t + 21, 2, 1'b0);
    pull_exp.push_back(t + 41);
    step_exp.push_back(t + 67);
    probe(t + 67, 0, 1'b0);
    $display("txn dry: pulls@%0d,%0d steps@%0d,%0d", t, t + 41, t + 21, t + 67);
    go(t + 40);
    pend_q.push_back(mk(32'd25, 16'd0, 16'd1));
    go(t + 90);

    // enable dropped after the first of five steps
    t = cyc + 1;
    pend_q.push_back(mk(32'd50, 16'd0, 16'd5));
    pull_exp.push_back(t);
    step_exp.push_back(t + 51);
    probe(t + 53, 0, 1'b0);
    probe(t + 54, 1, 1'b1);
    probe(t + 55, 1, 1'b0);
    probe(t + 60, 2, 1'b0);
    probe(t + 70, 0, 1'b0);
    pull_exp.push_back(t + 80);
    step_exp.push_back(t + 91);
    probe(t + 91, 0, 1'b0);
    $display("txn enable: pull@%0d disable@%0d re-pull@%0d", t, t + 52, t + 80);
    go(t + 52);
    enable = 1'b0;
    go(t + 55);
    pend_q.push_back(mk(32'd10, 16'd0, 16'd1));
    go(t + 80);
    enable = 1'b1;
    go(t + 110);

    // reset in the middle of a pulse
    t = cyc + 1;
    pend_q.push_back(mk(32'd20, 16'd0, 16'd2));
    pull_exp.push_back(t);
    step_exp.push_back(t + 21);
    probe(t + 22, 1, 1'b1);
    probe(t + 23, 1, 1'b0);
    probe(t + 23, 0, 1'b0);
    probe(t + 23, 2, 1'b0);
    $display("txn reset: pull@%0d reset@%0d", t, t + 22);
    go(t + 22);
    width_chk = 1'b0;
    rst = 1'b1;
    go(t + 24);
    rst = 1'b0;
    go(t + 26);
    width_chk = 1'b1;
    go(t + 60);

    chk("pull_left", pull_exp.size(), 0);
    chk("step_left", step_exp.size(), 0);
    chk("probe_left", probe_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stepper_exec.md
Name: stepper_exec

Overview:
- Consumer end of the move queue: pulls 64-bit move entries over the mq_data/mq_avail/mq_pull handshake and executes them as timed step pulses on a stepper step pin.
- Each entry is one timed move:
  - an initial step interval,
  - a signed per-step interval increment,
  - a step count.
- Moves chain back-to-back with no gap, so acceleration profiles built from consecutive entries are cycle-exact.

Parameters:
- PULSE_TICKS, 4, width of each step_pin high pulse in clk cycles; legal range 1..255.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- enable  input  1  execution enable; low = abort and hold idle
- mq_data  input  64  queue head entry; valid only while mq_avail=1
- mq_avail  input  1  queue holds an entry
- mq_pull  output  1  one-cycle pop strobe; entry consumed at this clk edge
- step_pin  output  1  step pulse output
- busy  output  1  a move is executing (state RUN)

Behaviour:
- Entry fields:
  - interval = mq_data[63:32], unsigned ticks.
  - add = mq_data[31:16], signed.
  - count = mq_data[15:0], unsigned.
- Effective interval: eff(x) = max(x, PULSE_TICKS+1). Clamping is applied at every timer load.
- States: IDLE, RUN.
- Reset values: state IDLE; step_pin 0; busy 0; mq_pull 0; all counters 0.
- mq_pull is combinational and asserts only when all three hold: enable=1, mq_avail=1, and a load is due.
- A load is due in two cases:
  - state is IDLE;
  - state is RUN and the current move finishes this cycle.
- Load, at the cycle T where mq_pull=1:
  - latch interval, add, count;
  - timer <= eff(interval);
  - state <= RUN.
- Timer behaviour in RUN:
  - The timer decrements each cycle. An event fires in the cycle timer==1.
  - For a load at cycle T, the first event fires at cycle T+eff(interval).
  - Later events are spaced by the updated interval.
- At each event:
  - if count != 0: emit a step; count <= count-1; interval <= interval + sext(add) (32-bit, modulo 2^32); timer <= eff(new interval).
  - The move finishes at the event where count reaches 0 (count was 1), or at the first event if count was 0 at load.
  - A count=0 entry is a pure delay: it waits eff(interval) cycles and emits no step.
- Move finish, in the same cycle as the finishing event:
  - if mq_avail=1: mq_pull=1 and the next entry loads, giving a back-to-back chain; the next first step is eff(interval) after this cycle;
  - else: state <= IDLE.
- Step pulse timing: step_pin goes high in the cycle after the step event and stays high for exactly PULSE_TICKS cycles.
  - Because of clamping, pulses never overlap.
  - A pulse in progress always completes, including across move loads and IDLE entry.
- busy = (state==RUN).
- enable low:
  - state forced to IDLE the next cycle; the current move is discarded and no pull occurs;
  - a pulse already in progress completes;
  - no new step is started.
- Reset in the middle of a move: everything returns to reset values the next cycle; step_pin drops immediately, truncating the pulse.
- mq_data is ignored whenever mq_pull=0.

Decomposition:
- Shared package (move-queue field definitions, shared with the queue writer):
  - constants MQ_INTERVAL_LSB=32, MQ_ADD_LSB=16, MQ_COUNT_LSB=0;
  - field widths 32/16/16.
- Sub-module step_pulse_gen:
  - inputs: clk, rst, fire;
  - output: step_pin;
  - internal 8-bit down-counter loaded with PULSE_TICKS on fire.
- stepper_exec holds the FSM, timer and interval arithmetic.

Test Plan:
- Single move, PULSE_TICKS=4: entry interval=100, add=0, count=3, pulled at T -> step_pin rising edges at T+101, T+201, T+301; each pulse 4 cycles high; busy falls at T+301.
- Acceleration: interval=1000, add=-100 (0xFF9C), count=4 -> rising-edge spacing 900, 800, 700 after the first edge at T+1001.
- Back-to-back: entry A (interval=50, count=1) followed by entry B (interval=60, count=1), with B already available -> second mq_pull in the same cycle as A's step event; B's step edge exactly 60 cycles after A's edge; busy stays 1 throughout.
- Clamp and delay:
  - interval=2, count=2, PULSE_TICKS=4 -> edges spaced 5 apart, no overlap;
  - interval=30, count=0 -> no pulse, and the next pull occurs 30 cycles after the load.
- Empty queue and enable:
  - move ends with mq_avail=0 -> state IDLE, no pull;
  - entry arrives later -> pull in the same cycle mq_avail rises;
  - enable=0 mid-move after 1 of 5 steps -> current pulse completes, no further steps, busy=0, no pull while enable stays low.
- Reset mid-pulse -> step_pin=0, busy=0, mq_pull=0 on the next cycle.
